// File: rtl/xbar_transfer_ctrl_pkg.sv
// Shared encodings for the crossbar transfer controller: opcodes, FSM states,
// the latched command record and the command legality check.
package xbar_transfer_ctrl_pkg;

  localparam int NREG_DEF = 4;
  localparam int TEMP_DEF = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOVE = 2'b01,
    OP_SWAP = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] rx;
    logic [1:0] ry;
  } cmd_t;

  // A swap that names the scratch register would destroy its own operand.
  function automatic logic cmd_rejected(input cmd_t c, input logic [1:0] temp);
    return (c.op == OP_RSVD) ||
           ((c.op == OP_SWAP) && ((c.rx == temp) || (c.ry == temp)));
  endfunction

endpackage

// File: rtl/xbar_onehot_dec.sv
// Register index to [1:NREG] one-hot strobe decoder; index 0 maps to bit 1.
module xbar_onehot_dec #(
  parameter int NREG = 4
) (
  input  logic [1:0]    i_idx,
  input  logic          i_en,
  output logic [1:NREG] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int k = 1; k <= NREG; k++) begin
      if (i_en && (i_idx == 2'(k - 1))) o_onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/xbar_transfer_ctrl.sv
// Sequencing controller for the 4-register shared-bus datapath (LOAD/MOVE/SWAP).
// Define XBAR_CTRL_QUEUE_EN to add a one-entry pending command buffer.
module xbar_transfer_ctrl
  import xbar_transfer_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int TEMP = TEMP_DEF
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          w,
  input  logic [1:0]    Op,
  input  logic [1:0]    Rx,
  input  logic [1:0]    Ry,
  output logic [1:NREG] Rin,
  output logic [1:NREG] Rout,
  output logic          Extern,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  output logic          Ready
);

  localparam logic [1:0] TEMP_IDX = TEMP[1:0];

  state_e        r_state, w_nxt_state;
  logic          r_multi, w_nxt_multi;
  logic [1:0]    r_rx, r_ry, w_nxt_rx, w_nxt_ry;
  logic [1:NREG] r_rin, r_rout;
  logic          r_extern, r_busy, r_done, r_err, r_ready;

  cmd_t          w_in_cmd, w_start_cmd;
  logic          w_final, w_start, w_drop;
  logic [1:0]    w_rin_idx, w_rout_idx;
  logic          w_rin_en, w_rout_en;
  logic          w_ext, w_busy, w_done, w_err, w_ready;
  logic [1:NREG] w_rin_oh, w_rout_oh;

`ifdef XBAR_CTRL_QUEUE_EN
  logic          r_q_vld, w_nxt_q_vld;
  cmd_t          r_q_cmd, w_nxt_q_cmd;
`endif

  assign w_in_cmd = cmd_t'({Op, Rx, Ry});
  assign w_final  = (r_state == ST_T3) || ((r_state == ST_T1) && !r_multi);

  // Decide whether a command enters T1 on the next edge, and from where.
  always_comb begin
    w_start     = 1'b0;
    w_start_cmd = w_in_cmd;
    w_drop      = 1'b0;
`ifdef XBAR_CTRL_QUEUE_EN
    w_nxt_q_vld = r_q_vld;
    w_nxt_q_cmd = r_q_cmd;
    if (r_state == ST_IDLE) begin
      w_start = w;
    end else if (r_q_vld) begin
      w_drop = w;
      if (w_final) begin
        w_start     = 1'b1;
        w_start_cmd = r_q_cmd;
        w_nxt_q_vld = 1'b0;
      end
    end else if (w) begin
      // A strobe in the last cycle chains straight into T1 instead of parking.
      if (w_final) begin
        w_start = 1'b1;
      end else begin
        w_nxt_q_vld = 1'b1;
        w_nxt_q_cmd = w_in_cmd;
      end
    end
`else
    w_start = (r_state == ST_IDLE) && w;
`endif
  end

  // Next-cycle transfer plan; every output below is registered from it.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_multi = r_multi;
    w_nxt_rx    = r_rx;
    w_nxt_ry    = r_ry;
    w_rin_idx   = '0;
    w_rin_en    = 1'b0;
    w_rout_idx  = '0;
    w_rout_en   = 1'b0;
    w_ext       = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_err       = w_drop;
    if (w_start) begin
      w_nxt_state = ST_T1;
      w_nxt_multi = 1'b0;
      w_nxt_rx    = w_start_cmd.rx;
      w_nxt_ry    = w_start_cmd.ry;
      if (cmd_rejected(w_start_cmd, TEMP_IDX)) begin
        w_err = 1'b1;
      end else begin
        w_busy = 1'b1;
        case (w_start_cmd.op)
          OP_LOAD: begin
            w_ext     = 1'b1;
            w_rin_en  = 1'b1;
            w_rin_idx = w_start_cmd.rx;
            w_done    = 1'b1;
          end
          OP_MOVE: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_start_cmd.ry;
            w_rin_en   = 1'b1;
            w_rin_idx  = w_start_cmd.rx;
            w_done     = 1'b1;
          end
          default: begin
            if (w_start_cmd.rx == w_start_cmd.ry) begin
              w_done = 1'b1;
            end else begin
              w_nxt_multi = 1'b1;
              w_rout_en   = 1'b1;
              w_rout_idx  = w_start_cmd.ry;
              w_rin_en    = 1'b1;
              w_rin_idx   = TEMP_IDX;
            end
          end
        endcase
      end
    end else if ((r_state == ST_T1) && r_multi) begin
      w_nxt_state = ST_T2;
      w_busy      = 1'b1;
      w_rout_en   = 1'b1;
      w_rout_idx  = r_rx;
      w_rin_en    = 1'b1;
      w_rin_idx   = r_ry;
    end else if (r_state == ST_T2) begin
      w_nxt_state = ST_T3;
      w_busy      = 1'b1;
      w_rout_en   = 1'b1;
      w_rout_idx  = TEMP_IDX;
      w_rin_en    = 1'b1;
      w_rin_idx   = r_rx;
      w_done      = 1'b1;
    end else if (w_final) begin
      w_nxt_state = ST_IDLE;
    end
  end

`ifdef XBAR_CTRL_QUEUE_EN
  assign w_ready = (w_nxt_state == ST_IDLE) || !w_nxt_q_vld;
`else
  assign w_ready = (w_nxt_state == ST_IDLE);
`endif

  xbar_onehot_dec #(.NREG(NREG)) u_rin_dec (
    .i_idx    (w_rin_idx),
    .i_en     (w_rin_en),
    .o_onehot (w_rin_oh)
  );

  xbar_onehot_dec #(.NREG(NREG)) u_rout_dec (
    .i_idx    (w_rout_idx),
    .i_en     (w_rout_en),
    .o_onehot (w_rout_oh)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_multi  <= 1'b0;
      r_rin    <= '0;
      r_rout   <= '0;
      r_extern <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_nxt_state;
      r_multi  <= w_nxt_multi;
      r_rin    <= w_rin_oh;
      r_rout   <= w_rout_oh;
      r_extern <= w_ext;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
      r_ready  <= w_ready;
    end
  end

  always_ff @(posedge Clock) begin
    r_rx <= w_nxt_rx;
    r_ry <= w_nxt_ry;
  end

`ifdef XBAR_CTRL_QUEUE_EN
  always_ff @(posedge Clock) begin
    if (Reset) r_q_vld <= 1'b0;
    else       r_q_vld <= w_nxt_q_vld;
    r_q_cmd <= w_nxt_q_cmd;
  end
`endif

  assign Rin    = r_rin;
  assign Rout   = r_rout;
  assign Extern = r_extern;
  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Err    = r_err;
  assign Ready  = r_ready;

endmodule

// File: tb/tb_xbar_transfer_ctrl.sv
// Scoreboard bench for xbar_transfer_ctrl: a command-level timeline model plus a
// bench-side register file driven by the controller's strobes.
module tb_xbar_transfer_ctrl;

  localparam logic [1:0] TEMP_I = 2'd3;
`ifdef XBAR_CTRL_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       Clock, Reset, w;
  logic [1:0] Op, Rx, Ry;
  logic [1:4] Rin, Rout;
  logic       Extern, Busy, Done, Err, Ready;

  xbar_transfer_ctrl dut (
    .Clock (Clock), .Reset (Reset), .w (w), .Op (Op), .Rx (Rx), .Ry (Ry),
    .Rin (Rin), .Rout (Rout), .Extern (Extern), .Busy (Busy), .Done (Done),
    .Err (Err), .Ready (Ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    int         cyc;
    logic [3:0] rin;
    logic [3:0] rout;
    logic       ext;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ext_q[$];
  logic [7:0] dp[4];
  logic [7:0] ref_r[4];
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int last_end = 0;
  int pend_until = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] idx);
    logic [3:0] base;
    base = 4'b1000;
    return base >> idx;
  endfunction

  // Insert an expected cycle, merging flags into an existing entry for that cycle.
  task automatic sb_add(input exp_t e);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == e.cyc) begin
        sb[i].rin  = sb[i].rin | e.rin;
        sb[i].rout = sb[i].rout | e.rout;
        sb[i].ext  = sb[i].ext | e.ext;
        sb[i].busy = sb[i].busy | e.busy;
        sb[i].done = sb[i].done | e.done;
        sb[i].err  = sb[i].err | e.err;
        return;
      end
      if (sb[i].cyc > e.cyc) begin
        sb.insert(i, e);
        return;
      end
    end
    sb.push_back(e);
  endtask

  // Command semantics: effect on registers plus the bus activity per cycle.
  task automatic start_cmd(input int c, input logic [1:0] op, input logic [1:0] rx,
                           input logic [1:0] ry, input logic [7:0] d);
    exp_t e;
    logic [7:0] tmp;
    e = '0;
    e.cyc = c;
    last_end = c;
    if (op == 2'b11 || (op == 2'b10 && (rx == TEMP_I || ry == TEMP_I))) begin
      e.err = 1'b1;
      sb_add(e);
    end else begin
      e.busy = 1'b1;
      case (op)
        2'b00: begin
          e.ext = 1'b1; e.rin = oh(rx); e.done = 1'b1;
          ext_q.push_back(d);
          ref_r[rx] = d;
          sb_add(e);
        end
        2'b01: begin
          e.rin = oh(rx); e.rout = oh(ry); e.done = 1'b1;
          ref_r[rx] = ref_r[ry];
          sb_add(e);
        end
        default: begin
          if (rx == ry) begin
            e.done = 1'b1;
            sb_add(e);
          end else begin
            tmp = ref_r[ry];
            ref_r[ry] = ref_r[rx];
            ref_r[rx] = tmp;
            ref_r[TEMP_I] = tmp;
            e.rout = oh(ry); e.rin = oh(TEMP_I);
            sb_add(e);
            e.cyc = c + 1; e.rout = oh(rx); e.rin = oh(ry);
            sb_add(e);
            e.cyc = c + 2; e.rout = oh(TEMP_I); e.rin = oh(rx); e.done = 1'b1;
            sb_add(e);
            last_end = c + 2;
          end
        end
      endcase
    end
  endtask

  function automatic logic model_ready(input int t);
    return (t > last_end) || (QEN && (t > pend_until));
  endfunction

  // A strobe raised during cycle t; activity starts no earlier than t+1.
  task automatic model_w(input int t, input logic [1:0] op, input logic [1:0] rx,
                         input logic [1:0] ry, input logic [7:0] d);
    exp_t e;
    if (t > last_end) begin
      start_cmd(t + 1, op, rx, ry, d);
    end else if (QEN) begin
      if (t > pend_until) begin
        if (t == last_end) begin
          start_cmd(t + 1, op, rx, ry, d);
        end else begin
          pend_until = last_end;
          start_cmd(last_end + 1, op, rx, ry, d);
        end
      end else begin
        e = '0;
        e.cyc = t + 1;
        e.err = 1'b1;
        sb_add(e);
      end
    end
  endtask

  // Monitor: compare every cycle against the timeline and drive the register file.
  always @(negedge Clock) begin
    exp_t e;
    logic [7:0] bus;
    if (cyc >= 1) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("stale_entry", 32'(e.cyc), 32'(cyc));
      end
      e = '0;
      e.cyc = cyc;
      if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front();
      chk("outputs{Rin,Rout,Ext,Busy,Done,Err}",
          32'({Rin, Rout, Extern, Busy, Done, Err}),
          32'({e.rin, e.rout, e.ext, e.busy, e.done, e.err}));
      chk("bus_exclusive",
          32'(($countones({Extern, Rout}) <= 1) && ($countones(Rin) <= 1)), 32'd1);
      bus = 8'h00;
      if (Extern === 1'b1) begin
        if (ext_q.size() > 0) bus = ext_q.pop_front();
        else chk("extern_without_load", 32'd1, 32'd0);
      end
      for (int k = 0; k < 4; k++) if (Rout[k+1] === 1'b1) bus = dp[k];
      for (int k = 0; k < 4; k++) if (Rin[k+1] === 1'b1) dp[k] = bus;
    end
  end

  task automatic cmd(input logic [1:0] op, input logic [1:0] rx, input logic [1:0] ry,
                     input logic [7:0] d);
    chk("ready", 32'(Ready), 32'(model_ready(cyc)));
    w = 1'b1; Op = op; Rx = rx; Ry = ry;
    model_w(cyc, op, rx, ry, d);
    @(negedge Clock);
    w = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      chk("ready", 32'(Ready), 32'(model_ready(cyc)));
      @(negedge Clock);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
    last_end = cyc;
    pend_until = cyc;
    ext_q.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    idle(3);
    for (int k = 0; k < 4; k++) ref_r[k] = dp[k];
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 4; k++) chk(tag, 32'(dp[k]), 32'(ref_r[k]));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin dp[k] = 8'h00; ref_r[k] = 8'h00; end
    Reset = 1'b1; w = 1'b0; Op = 2'b00; Rx = 2'b00; Ry = 2'b00;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    chk("ready_after_reset", 32'(Ready), 32'd1);

    cmd(2'b00, 2'd0, 2'd0, 8'hCA); idle(1);
    cmd(2'b00, 2'd1, 2'd0, 8'hFE); idle(1);
    cmd(2'b01, 2'd2, 2'd1, 8'h00); idle(1);
    chk("R3_after_move", 32'(dp[2]), 32'h0000_00FE);
    cmd(2'b10, 2'd0, 2'd1, 8'h00); idle(4);
    chk("R1_after_swap", 32'(dp[0]), 32'h0000_00FE);
    chk("R2_after_swap", 32'(dp[1]), 32'h0000_00CA);
    chk("R4_after_swap", 32'(dp[3]), 32'h0000_00FE);
    check_regs("regs_directed");

    cmd(2'b11, 2'd1, 2'd2, 8'h00); idle(2);
    cmd(2'b10, 2'd0, 2'd3, 8'h00); idle(2);
    cmd(2'b10, 2'd2, 2'd2, 8'h00); idle(2);

    // Strobes during a swap: ignored, or buffered/dropped when queueing is built in.
    cmd(2'b10, 2'd0, 2'd1, 8'h00);
    cmd(2'b01, 2'd2, 2'd0, 8'h00);
    cmd(2'b00, 2'd1, 2'd0, 8'h5A);
    idle(6);
    check_regs("regs_overlap");

    cmd(2'b10, 2'd1, 2'd2, 8'h00);
    idle(1);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1)
        cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom));
      else
        idle(1);
    end
    idle(8);
    check_regs("regs_random");
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
